// File: rtl/inst_pkg.sv
// inst_pkg: shared field layout for R-type instruction words.
// Holds field LSB positions, the R-type opcode and the packed word struct.
package inst_pkg;

  localparam int OP_LSB   = 0;
  localparam int RD_LSB   = 7;
  localparam int F3_LSB   = 12;
  localparam int RS1_LSB  = 15;
  localparam int RS2_LSB  = 20;
  localparam int F7_LSB   = 25;
  localparam int F_EN_BIT = 28;

  localparam logic [6:0] OP_R = 7'h33;

  // funct7 is split around bit 28, which carries the float enable.
  typedef struct packed {
    logic [2:0] f7_hi;
    logic       f_en;
    logic [2:0] f7_lo;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] op;
  } inst_r_t;

endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: instruction word FIFO with synchronous flush.
// Ports: clk, rst, i_flush, i_push/i_data, i_pop, o_data, o_full, o_empty.
module inst_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Full/empty come only from the registered count, so a pop
  // on a full FIFO never frees a slot in the same cycle.
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push && !rst && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/inst_enc.sv
// inst_enc: packs R-type fields into words, queues and issues them.
// Ports: clk, rst, flush, in_valid/in_ready + fields (op, rd, func3, rs1,
// rs2, func7, f_en), out_valid/out_ready/inst, conflict, issued_cnt.
// Define INST_ENC_CNT_EN to enable the issued_cnt pop counter.
module inst_enc
  import inst_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [6:0]   op,
  input  logic [4:0]   rd,
  input  logic [2:0]   func3,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  input  logic [6:0]   func7,
  input  logic         f_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] inst,
  output logic         conflict,
  output logic [15:0]  issued_cnt
);

  if (W != 32) begin : g_bad_w
    $error("inst_enc: W must be 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inst_enc: DEPTH must be a power of 2, >= 2");
  end

  inst_r_t      w_fields;
  logic [W-1:0] w_word;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         r_conflict;

  // f_en always lands on bit 28; func7[3] is dropped from the word.
  always_comb begin
    w_fields       = '0;
    w_fields.f7_hi = func7[6:4];
    w_fields.f_en  = f_en;
    w_fields.f7_lo = func7[2:0];
    w_fields.rs2   = rs2;
    w_fields.rs1   = rs1;
    w_fields.func3 = func3;
    w_fields.rd    = rd;
    w_fields.op    = op;
  end

  assign w_word    = W'(w_fields);
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready;
  assign conflict  = r_conflict;

  inst_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (out_ready),
    .o_data  (inst),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_conflict <= 1'b0;
    end else if (w_push &&
                 (func7[F_EN_BIT-F7_LSB] != f_en)) begin
      r_conflict <= 1'b1;
    end
  end

`ifdef INST_ENC_CNT_EN
  logic        w_pop;
  logic [15:0] r_cnt;

  assign w_pop      = out_valid && out_ready;
  assign issued_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`else
  assign issued_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_inst_enc.sv
// tb_inst_enc: scoreboard bench for inst_enc.
// Directed field vectors with hand-computed words.
module tb_inst_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  func7;
  logic        f_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        conflict;
  logic [15:0] issued_cnt;

  int checks   = 0;
  int failures = 0;
  logic [31:0] q[$];

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic        fen;
    logic [31:0] word;
  } vec_t;

  vec_t vt[7];

  always #5 clk = ~clk;

  inst_enc dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .rd         (rd),
    .func3      (func3),
    .rs1        (rs1),
    .rs2        (rs2),
    .func7      (func7),
    .f_en       (f_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .inst       (inst),
    .conflict   (conflict),
    .issued_cnt (issued_cnt)
  );

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops one expected word.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual=%h required=none", inst);
      end else begin
        check("pop_word", inst, q.pop_front());
      end
    end
  end

  task automatic drive(int k);
    op    = vt[k].op;
    rd    = vt[k].rd;
    func3 = vt[k].f3;
    rs1   = vt[k].rs1;
    rs2   = vt[k].rs2;
    func7 = vt[k].f7;
    f_en  = vt[k].fen;
  endtask

  task automatic push(int k);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("push_wait_timeout", 32'(in_ready), 32'd1);
    end else begin
      drive(k);
      in_valid = 1'b1;
      q.push_back(vt[k].word);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_done", 32'(q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{7'h33, 5'd5,  3'd0, 5'd3,  5'd2,  7'h08, 1'b1, 32'h102182B3};
    vt[1] = '{7'h33, 5'd5,  3'd0, 5'd3,  5'd2,  7'h00, 1'b1, 32'h102182B3};
    vt[2] = '{7'h33, 5'd1,  3'd7, 5'd2,  5'd3,  7'h20, 1'b0, 32'h403170B3};
    vt[3] = '{7'h53, 5'd31, 3'd1, 5'd31, 5'd31, 7'h7F, 1'b1, 32'hFFFF9FD3};
    vt[4] = '{7'h13, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 1'b0, 32'h00000013};
    vt[5] = '{7'h33, 5'd10, 3'd5, 5'd4,  5'd6,  7'h01, 1'b0, 32'h02625533};
    vt[6] = '{7'h33, 5'd0,  3'd0, 5'd0,  5'd0,  7'h08, 1'b0, 32'h00000033};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(4);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_conflict", 32'(conflict), 32'd0);
    check("rst_issued_cnt", 32'(issued_cnt), 32'd0);

    // T1: basic encode, one-cycle latency.
    out_ready = 1'b1;
    push(0);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_inst", inst, 32'h102182B3);
    check("t1_conflict", 32'(conflict), 32'd0);
    @(posedge clk); #1;

    // T2: func7[3] disagrees with f_en -> sticky conflict.
    push(1);
    check("t2_conflict_n1", 32'(conflict), 32'd1);
    repeat (3) @(posedge clk);
    #1 check("t2_conflict_held", 32'(conflict), 32'd1);
    check("t2_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("t2_conflict_flushed", 32'(conflict), 32'd0);

    // T3: fill with out_ready=0; 5th push ignored.
    push(2); push(3); push(4); push(5);
    check("t3_full_in_ready", 32'(in_ready), 32'd0);
    check("t3_out_valid", 32'(out_valid), 32'd1);
    drive(6);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("t3_still_full", 32'(in_ready), 32'd0);
    check("t3_no_conflict", 32'(conflict), 32'd0);
    check("t3_head_stable", inst, 32'h40317FB3 ^ 32'h00000F00);

    // T4: full + push + pop same cycle -> pop only.
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_no_conflict", 32'(conflict), 32'd0);
    check("t4_left3", 32'(q.size()), 32'd3);
    drain();

    // T5: flush with in_valid drops everything.
    out_ready = 1'b0;
    push(2); push(3); push(4);
    drive(6);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_conflict", 32'(conflict), 32'd0);
    repeat (2) @(posedge clk);
    #1 check("t5_dropped", 32'(out_valid), 32'd0);
    check("t5_cnt_clr", 32'(issued_cnt), 32'd0);

    // T6: ten pops, then reset mid-stream.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(i % 7);
    drain();
`ifdef INST_ENC_CNT_EN
    check("t6_cnt10", 32'(issued_cnt), 32'd10);
`else
    check("t6_cnt0", 32'(issued_cnt), 32'd0);
`endif
    out_ready = 1'b0;
    push(6); push(2);
    check("t6_pre_rst_valid", 32'(out_valid), 32'd1);
    check("t6_pre_rst_conf", 32'(conflict), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    check("t6_rst_cnt", 32'(issued_cnt), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_conflict", 32'(conflict), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
